// File: rtl/knight_uart_pkg.sv
// knight_uart_pkg: shared constants and state types for the command UART link.
//   RESP_DONE / RESP_TRMT : response codes sent back to the host
//   rx_state_t  : receive bit-engine states
//   asm_state_t : two-byte command assembly states
//   tx_state_t  : response serialiser states
package knight_uart_pkg;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_TRMT = 8'h5A;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {ASM_WAIT_HI, ASM_WAIT_LO}             asm_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver bit engine.
//   clk, rst  : clock, async active-high reset
//   RX        : raw serial input (idle high, asynchronous)
//   rx_byte   : last shifted byte (valid while rx_valid is high)
//   rx_valid  : pulse, byte received with good stop bit
//   rx_start  : pulse, start bit confirmed at mid-bit
//   rx_ferr   : pulse, stop bit read 0, byte discarded
module uart_rx_core
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       rx_ferr
);

  localparam int CW = $clog2(BAUD_DIV);

  logic            rx_s1, rx_s2, rx_s3;
  rx_state_t       st;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            half_tick, full_tick, fall;

  assign half_tick = (cnt == CW'(BAUD_DIV/2 - 1));
  assign full_tick = (cnt == CW'(BAUD_DIV - 1));
  // rx_s3 only serves edge detection; it is a delayed copy of the synced line
  assign fall      = rx_s3 & ~rx_s2;

  assign rx_byte  = shreg;
  assign rx_start = (st == RX_START) && half_tick && !rx_s2;
  assign rx_valid = (st == RX_STOP)  && full_tick &&  rx_s2;
  assign rx_ferr  = (st == RX_STOP)  && full_tick && !rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) st <= RX_START;
        end
        RX_START: begin
          if (half_tick) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // line back high at mid start bit: a glitch, not a frame
            st      <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (full_tick) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (full_tick) begin
            cnt <= '0;
            st  <= RX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_uart_responder.sv
// cmd_uart_responder: device end of the host command link.
//   clk, rst    : clock, async active-high reset
//   RX / TX     : serial in / out, both idle high
//   cmd         : last complete command {high, low}
//   cmd_rdy     : level, unconsumed cmd present
//   clr_cmd_rdy : consume strobe
//   resp        : response byte, latched on send_resp
//   send_resp   : transmit request (ignored while busy)
//   resp_sent   : pulse on last cycle of the stop bit
//   tx_busy     : response frame in progress
module cmd_uart_responder
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV     = 5208,
  parameter int BYTE_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int CW   = $clog2(BAUD_DIV);
  localparam int TO_W = $clog2(BYTE_TIMEOUT + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_start, rx_ferr;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_start (rx_start),
    .rx_ferr  (rx_ferr)
  );

  // ---------------- command assembly ----------------
  asm_state_t      asm_st;
  logic [7:0]      hi_reg;
  logic [TO_W-1:0] to_cnt;
  logic            lo_started;  // low byte start seen: timeout no longer applies

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_st     <= ASM_WAIT_HI;
      hi_reg     <= '0;
      cmd        <= '0;
      to_cnt     <= '0;
      lo_started <= 1'b0;
    end else begin
      case (asm_st)
        ASM_WAIT_HI: begin
          if (rx_valid) begin
            hi_reg     <= rx_byte;
            to_cnt     <= '0;
            lo_started <= 1'b0;
            asm_st     <= ASM_WAIT_LO;
          end
        end
        ASM_WAIT_LO: begin
          if (to_cnt != TO_W'(BYTE_TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
          if (rx_valid) begin
            cmd    <= {hi_reg, rx_byte};
            asm_st <= ASM_WAIT_HI;
          end else if (rx_ferr) begin
            asm_st <= ASM_WAIT_HI;
          end else if (rx_start) begin
            lo_started <= 1'b1;
          end else if (!lo_started && to_cnt == TO_W'(BYTE_TIMEOUT)) begin
            hi_reg <= '0;
            asm_st <= ASM_WAIT_HI;
          end
        end
        default: asm_st <= ASM_WAIT_HI;
      endcase
    end
  end

  // set beats clear; a new high byte start withdraws the stale command
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cmd_rdy <= 1'b0;
    else if (asm_st == ASM_WAIT_LO && rx_valid)
      cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy || (asm_st == ASM_WAIT_HI && rx_start))
      cmd_rdy <= 1'b0;
  end

  // ---------------- response serialiser ----------------
  tx_state_t     tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick   = (tx_cnt == CW'(BAUD_DIV - 1));
  assign resp_sent = (tx_st == TX_STOP) && tx_tick;
  assign tx_busy   = (tx_st != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      TX     <= 1'b1;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (send_resp) begin
            tx_sh <= resp;
            TX    <= 1'b0;
            tx_st <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            TX     <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_st  <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              TX    <= 1'b1;
              tx_st <= TX_STOP;
            end else begin
              TX     <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_st  <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_responder.sv
module tb_cmd_uart_responder;
  import knight_uart_pkg::*;

  logic        clk, rst, rx, tx;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy;
  logic [7:0]  resp;

  int n_vec = 0;
  int n_bad = 0;

  cmd_uart_responder #(.BAUD_DIV(16), .BYTE_TIMEOUT(400)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (rx),
    .TX          (tx),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        lo_stop;
    int          gap;
    logic        exp_rdy;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // host-side 8N1 frame, 16 cycles per bit, driven on falling clock edges
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] a5_bits;
    int         sent_cnt, sent_cyc, got;

    vecs[0] = '{8'h12, 8'h34, 1'b1, 0,   1'b1, 16'h1234};
    vecs[1] = '{8'hA5, 8'h5A, 1'b1, 100, 1'b1, 16'hA55A};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 0,   1'b1, 16'hFF00};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 20,  1'b1, 16'h00FF};
    vecs[4] = '{8'h81, 8'h7E, 1'b1, 300, 1'b1, 16'h817E};
    vecs[5] = '{8'h3C, 8'hC3, 1'b0, 0,   1'b0, 16'h817E};

    rst = 1'b1; rx = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", {15'd0, tx}, 16'd1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_resp_sent", {15'd0, resp_sent}, 16'd0);
    chk("rst_tx_busy", {15'd0, tx_busy}, 16'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // ---- table: two-byte commands ----
    for (int v = 0; v < 6; v++) begin
      uart_send(vecs[v].hi, 1'b1);
      repeat (vecs[v].gap) @(negedge clk);
      uart_send(vecs[v].lo, vecs[v].lo_stop);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_rdy", v), {15'd0, cmd_rdy}, {15'd0, vecs[v].exp_rdy});
      chk($sformatf("vec%0d_cmd", v), cmd, vecs[v].exp_cmd);
      clr_pulse();
      repeat (3) @(negedge clk);
    end

    // ---- exact cmd_rdy latency, clear coinciding with completion ----
    uart_send(8'h12, 1'b1);
    fork
      uart_send(8'h34, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        #1 chk("lat_rdy_early", {15'd0, cmd_rdy}, 16'd0);
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 chk("lat_rdy_set_wins", {15'd0, cmd_rdy}, 16'd1);
        chk("lat_cmd", cmd, 16'h1234);
        @(negedge clk); clr_cmd_rdy = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("still_rdy", {15'd0, cmd_rdy}, 16'd1);
    clr_pulse();
    chk("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("clr_cmd_hold", cmd, 16'h1234);

    // ---- response frame, second request while busy ignored ----
    a5_bits  = 10'b1_10100101_0;  // stop, data MSB..LSB, start (index 0 first)
    sent_cnt = 0; sent_cyc = 0;
    @(negedge clk); resp = RESP_DONE; send_resp = 1'b1;
    for (int c = 1; c <= 170; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("tx_busy_rise", {15'd0, tx_busy}, 16'd1);
      if (c <= 160 && ((c - 1) % 16) == 8)
        chk($sformatf("tx_bit%0d", (c - 1) / 16), {15'd0, tx}, {15'd0, a5_bits[(c - 1) / 16]});
      if (resp_sent) begin sent_cnt++; sent_cyc = c; end
      if (c == 161) chk("tx_busy_fall", {15'd0, tx_busy}, 16'd0);
      @(negedge clk);
      send_resp = (c == 49);
      resp      = (c == 49) ? 8'h00 : RESP_DONE;
    end
    chk("resp_sent_cnt", 16'(sent_cnt), 16'd1);
    chk("resp_sent_cyc", 16'(sent_cyc), 16'd160);
    chk("tx_idle_after", {15'd0, tx}, 16'd1);
    chk("tx_busy_after", {15'd0, tx_busy}, 16'd0);

    // ---- inter-byte timeout drops the orphaned high byte ----
    uart_send(8'hAB, 1'b1);
    repeat (500) @(negedge clk);
    chk("to_no_rdy", {15'd0, cmd_rdy}, 16'd0);
    uart_send(8'hCD, 1'b1);
    uart_send(8'hEF, 1'b1);
    repeat (4) @(negedge clk);
    chk("to_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("to_cmd", cmd, 16'hCDEF);

    // ---- short low glitch on idle line ----
    @(negedge clk); rx = 1'b0;
    repeat (6) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("glitch_cmd", cmd, 16'hCDEF);

    // ---- framing error on the low byte ----
    uart_send(8'h9A, 1'b1);
    uart_send(8'hBC, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("ferr_cmd", cmd, 16'hCDEF);
    uart_send(8'h56, 1'b1);
    uart_send(8'h78, 1'b1);
    repeat (4) @(negedge clk);
    chk("ferr_next_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("ferr_next_cmd", cmd, 16'h5678);

    // ---- reset mid TX frame and mid RX frame ----
    @(negedge clk); resp = RESP_TRMT; send_resp = 1'b1; rx = 1'b0;
    @(negedge clk); send_resp = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_busy", {15'd0, tx_busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", {15'd0, tx}, 16'd1);
    chk("arst_busy", {15'd0, tx_busy}, 16'd0);
    chk("arst_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("arst_cmd", cmd, 16'h0000);
    @(negedge clk); rx = 1'b1;
    repeat (4) @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    uart_send(8'h13, 1'b1);
    uart_send(8'h57, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("post_rst_cmd", cmd, 16'h1357);
    @(negedge clk); resp = RESP_DONE; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      @(posedge clk); #1;
      if (resp_sent) got = 1;
    end
    chk("post_rst_resp_sent", 16'(got), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
